// File: rtl/counter_reg_bank_if.sv
// ---------------------------------------------------------------------------
// counter_reg_bank_if
// Processor-side (PS) register bus used to reach the counter bank.
//   ps_addr  : byte address
//   ps_wren  : write strobe, ps_wdat is the write data
//   ps_rden  : read strobe
//   ps_rdat  : registered read data, 0 when ps_rvld is low
//   ps_rvld  : read data valid, one cycle after a decoded ps_rden
// Modports: master (bus driver) and slave (register block).
// ---------------------------------------------------------------------------
interface counter_reg_bank_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] ps_addr;
   logic                  ps_wren;
   logic [DATA_WIDTH-1:0] ps_wdat;
   logic                  ps_rden;
   logic [DATA_WIDTH-1:0] ps_rdat;
   logic                  ps_rvld;

   modport master (
      output ps_addr, ps_wren, ps_wdat, ps_rden,
      input  ps_rdat, ps_rvld
   );

   modport slave (
      input  ps_addr, ps_wren, ps_wdat, ps_rden,
      output ps_rdat, ps_rvld
   );
endinterface

// File: rtl/counter_reg_bank.sv
// ---------------------------------------------------------------------------
// counter_reg_bank
// NUM_CH independent event counters, each bounded by its own terminal value,
// with per-channel wrap/saturate mode, sticky wrap flags and a PS register
// port for read-back and clearing.
//
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset, released synchronously
//   ienb     : per-channel count enable
//   imax     : per-channel terminal value, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ostatus  : live counter values, same packing as imax
//   owrap    : one-cycle pulse on wrap (wrap mode) or on reaching imax (saturate)
//   ps       : PS register bus (slave side of counter_reg_bank_if)
//
// Register map (byte addresses, word spaced):
//   BASE_ADDR + 4*i          CNT[i]   write CLR_CODE to clear, other values ignored
//   BASE_ADDR + 4*NUM_CH     WRAP_STS sticky wrap flags, write-1-to-clear
//   BASE_ADDR + 4*(NUM_CH+1) MODE     bit i = 1 selects saturate for channel i
//   BASE_ADDR + 4*(NUM_CH+2) SNAP     only when COUNTER_REG_SNAPSHOT_EN is defined
//
// Optional feature, macro COUNTER_REG_SNAPSHOT_EN: any SNAP write copies all
// counters into shadow registers; CNT reads then return the shadows and SNAP
// reads return a wrapping snapshot sequence count.
// ---------------------------------------------------------------------------
module counter_reg_bank #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    NUM_CH     = 4,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter logic [DATA_WIDTH-1:0] CLR_CODE   = DATA_WIDTH'(1)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_CH-1:0]            ienb,
   input  logic [NUM_CH*DATA_WIDTH-1:0] imax,
   output logic [NUM_CH*DATA_WIDTH-1:0] ostatus,
   output logic [NUM_CH-1:0]            owrap,
   counter_reg_bank_if.slave            ps
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] cnt;
      logic                  hit;
   } step_t;

   function automatic logic [ADDR_WIDTH-1:0] word_addr(input int idx);
      return BASE_ADDR + ADDR_WIDTH'(4 * idx);
   endfunction

   // One enabled count step. The >= test keeps the counter bounded when the
   // terminal value is lowered below the current count. In saturate mode the
   // flag fires only on the increment that lands exactly on the limit.
   function automatic step_t count_step(input logic [DATA_WIDTH-1:0] cnt,
                                        input logic [DATA_WIDTH-1:0] lim,
                                        input logic                  sat);
      step_t r;
      r.cnt = cnt + DATA_WIDTH'(1);
      r.hit = 1'b0;
      if (cnt >= lim) begin
         r.cnt = sat ? lim : '0;
         r.hit = !sat;
      end else begin
         r.hit = sat && (r.cnt == lim);
      end
      return r;
   endfunction

   logic [DATA_WIDTH-1:0] cnt_q [NUM_CH];
   logic [DATA_WIDTH-1:0] cnt_d [NUM_CH];
   logic [NUM_CH-1:0]     wrap_sts_q, sts_d;
   logic [NUM_CH-1:0]     mode_q;
   logic [NUM_CH-1:0]     owrap_q, hit_d;
   logic [NUM_CH-1:0]     clr;
   logic                  sts_wr, mode_wr;
   step_t                 step_c;
   logic                  rd_hit;
   logic [DATA_WIDTH-1:0] rd_val;
   logic [DATA_WIDTH-1:0] rdat_p1;
   logic                  vld_p1;

`ifdef COUNTER_REG_SNAPSHOT_EN
   logic [DATA_WIDTH-1:0] shadow_q [NUM_CH];
   logic [DATA_WIDTH-1:0] snap_seq_q;
   logic                  snap_wr;
`endif

   // ---- p0: write decode, count update, read mux ----
   always_comb begin
      clr     = '0;
      hit_d   = '0;
      step_c  = '0;
      sts_wr  = ps.ps_wren && (ps.ps_addr == word_addr(NUM_CH));
      mode_wr = ps.ps_wren && (ps.ps_addr == word_addr(NUM_CH + 1));
`ifdef COUNTER_REG_SNAPSHOT_EN
      snap_wr = ps.ps_wren && (ps.ps_addr == word_addr(NUM_CH + 2));
`endif
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i] = cnt_q[i];
         step_c   = count_step(cnt_q[i], imax[i*DATA_WIDTH +: DATA_WIDTH], mode_q[i]);
         clr[i]   = ps.ps_wren && (ps.ps_addr == word_addr(i)) && (ps.ps_wdat == CLR_CODE);
         // A clear beats a same-cycle count and suppresses its flag.
         if (clr[i]) begin
            cnt_d[i] = '0;
         end else if (ienb[i]) begin
            cnt_d[i] = step_c.cnt;
            hit_d[i] = step_c.hit;
         end
      end

      // Hardware set is applied after W1C so a same-cycle set survives.
      sts_d = wrap_sts_q;
      if (sts_wr) begin
         sts_d = sts_d & ~ps.ps_wdat[NUM_CH-1:0];
      end
      sts_d = sts_d | hit_d;

      rd_hit = 1'b0;
      rd_val = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ps.ps_addr == word_addr(i)) begin
            rd_hit = 1'b1;
`ifdef COUNTER_REG_SNAPSHOT_EN
            rd_val = shadow_q[i];
`else
            rd_val = cnt_q[i];
`endif
         end
      end
      if (ps.ps_addr == word_addr(NUM_CH)) begin
         rd_hit               = 1'b1;
         rd_val[NUM_CH-1:0]   = wrap_sts_q;
      end
      if (ps.ps_addr == word_addr(NUM_CH + 1)) begin
         rd_hit               = 1'b1;
         rd_val[NUM_CH-1:0]   = mode_q;
      end
`ifdef COUNTER_REG_SNAPSHOT_EN
      if (ps.ps_addr == word_addr(NUM_CH + 2)) begin
         rd_hit = 1'b1;
         rd_val = snap_seq_q;
      end
`endif
   end

   // ---- p1: state registers and registered read port ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= '0;
         end
         wrap_sts_q <= '0;
         mode_q     <= '0;
         owrap_q    <= '0;
         rdat_p1    <= '0;
         vld_p1     <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         wrap_sts_q <= sts_d;
         if (mode_wr) begin
            mode_q <= ps.ps_wdat[NUM_CH-1:0];
         end
         owrap_q <= hit_d;
         vld_p1  <= ps.ps_rden && rd_hit;
         rdat_p1 <= (ps.ps_rden && rd_hit) ? rd_val : '0;
      end
   end

`ifdef COUNTER_REG_SNAPSHOT_EN
   // Shadows capture the pre-edge counter values, same edge as the SNAP write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            shadow_q[i] <= '0;
         end
         snap_seq_q <= '0;
      end else if (snap_wr) begin
         for (int i = 0; i < NUM_CH; i++) begin
            shadow_q[i] <= cnt_q[i];
         end
         snap_seq_q <= snap_seq_q + DATA_WIDTH'(1);
      end
   end
`endif

   always_comb begin
      ostatus = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ostatus[i*DATA_WIDTH +: DATA_WIDTH] = cnt_q[i];
      end
   end

   assign owrap      = owrap_q;
   assign ps.ps_rdat = rdat_p1;
   assign ps.ps_rvld = vld_p1;

endmodule

// File: doc/counter_reg_bank.md
Name: counter_reg_bank

Overview:
- Multi-channel status-counter bank: NUM_CH independent event counters, each with its own terminal value.
- Per-channel wrap or saturate mode; sticky wrap flags; PS-side clear.
- Registered PS read port and PS write port.
- Sits beside the accelerator datapath as its performance/status register block, on the shared PS address bus.

Parameters:
- DATA_WIDTH, 32, width of each counter, terminal value and PS data bus
- ADDR_WIDTH, 32, PS address width
- NUM_CH, 4, number of counter channels (1..32)
- BASE_ADDR, 32'h00000000, byte address of channel 0 counter
- CLR_CODE, 32'h00000001, write value that clears a counter

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- ienb  input  NUM_CH  per-channel count enable (bit i → channel i)
- imax  input  NUM_CH*DATA_WIDTH  per-channel terminal value, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
- ostatus  output  NUM_CH*DATA_WIDTH  live counter values, same packing as imax
- owrap  output  NUM_CH  one-cycle pulse when channel i wraps or first saturates
- ps_addr  input  ADDR_WIDTH  PS byte address
- ps_wren  input  1  PS write strobe
- ps_wdat  input  DATA_WIDTH  PS write data
- ps_rden  input  1  PS read strobe
- ps_rdat  output  DATA_WIDTH  PS read data, 0 when not valid
- ps_rvld  output  1  PS read data valid

Behaviour:
- Address map (word-spaced, 4 bytes):
  - CNT[i] at BASE_ADDR+4*i
  - WRAP_STS at BASE_ADDR+4*NUM_CH
  - MODE at BASE_ADDR+4*(NUM_CH+1)
  - SNAP at BASE_ADDR+4*(NUM_CH+2), present only with the optional feature
- Reset (rst low, asynchronous): all counters, WRAP_STS, MODE, owrap, ps_rdat and ps_rvld go to 0. Release is synchronous to clk. A reset mid-count discards all state.
- Counting, channel i with ienb[i]=1:
  - Wrap mode (MODE[i]=0): if counter >= imax[i], counter becomes 0, owrap[i] pulses, WRAP_STS[i] is set. Otherwise counter increments by 1.
  - Saturate mode (MODE[i]=1): if counter < imax[i], counter increments. If counter >= imax[i], counter takes imax[i].
  - owrap[i] and the WRAP_STS[i] set fire only on the increment that reaches imax[i].
  - The >= comparison keeps the counter bounded when imax is lowered below the current value.
- imax[i]=0:
  - Wrap mode: counter stays 0 and owrap[i] pulses every enabled cycle.
  - Saturate mode: counter stays 0 with no pulse.
- Writes (ps_wren=1):
  - CNT[i]: if ps_wdat==CLR_CODE, counter i becomes 0. Other values are ignored.
  - WRAP_STS: write-1-to-clear, bit i cleared where ps_wdat[i]=1.
  - MODE: low NUM_CH bits are written; upper bits are ignored and read as 0.
  - A write to CNT or MODE takes effect on the next edge.
- Simultaneous events:
  - Clear write and ienb on the same channel: clear wins, counter=0, no owrap pulse.
  - W1C and a hardware set of the same WRAP_STS bit: the set wins, bit stays 1.
- Reads:
  - Registered, 1-cycle latency: ps_rden with a decoded address in cycle N gives ps_rvld=1 and ps_rdat=value in cycle N+1.
  - The value returned is the register content at edge N, i.e. before any same-cycle write or count.
  - An undecoded address gives ps_rvld=0 and ps_rdat=0. Back-to-back reads are supported every cycle.
- Counter arithmetic: unsigned modulo 2^DATA_WIDTH; imax=all-ones wraps naturally.

Optional Feature:
- Macro: COUNTER_REG_SNAPSHOT_EN.
- With the macro defined:
  - Any write to SNAP copies all NUM_CH counters into shadow registers on the same edge.
  - CNT[i] reads return the shadow value.
  - A SNAP read returns the snapshot sequence count, which increments per snapshot and wraps.
  - Shadows and the sequence count reset to 0.
- Without it: SNAP is undecoded, CNT reads return live counters, no shadow storage is built.

Test Plan:
- Reset check: NUM_CH=4, imax[0]=3, MODE=0, ienb[0] held 1 for 10 cycles → ostatus[0] sequence 0,1,2,3,0,1,2,3,0,1; owrap[0] pulses on each 3→0; WRAP_STS=0x1.
- Saturate: MODE=0x2, imax[1]=5, ienb[1] held 1 for 9 cycles → counter 1 stops at 5; single owrap[1] pulse on 4→5; reading CNT[1] returns 5 with ps_rvld one cycle after ps_rden.
- Clear collision: counter 2 at 7, write CLR_CODE to BASE+8 while ienb[2]=1 → counter 2=0 next cycle; a write of 0x2 to BASE+8 leaves it counting.
- W1C vs set: WRAP_STS=0x1; write 0x1 to WRAP_STS in the same cycle channel 0 wraps → bit stays 1; a later write of 0x1 → reads 0.
- Async reset mid-run: drop rst between clock edges while counters are nonzero → ostatus, WRAP_STS, MODE and ps_rvld read 0 immediately; counting resumes from 0 after release.
- With COUNTER_REG_SNAPSHOT_EN: counters at {4,9,0,1}, write SNAP, keep counting → CNT reads return {4,9,0,1}; SNAP reads 1.
